// File: rtl/axiline_input_loader.sv
// Packs a narrow element stream into full-width rows and double-buffers them for the
// Axiline accelerator. It also sequences the start/done pulses for one epoch.
module axiline_input_loader #(
    parameter int inputBitwidth  = 8,
    parameter int size           = 4,
    parameter int numUnit        = 1,
    parameter int logNumCycle    = 1,
    parameter int numCycle       = 2,
    parameter int sampleBitwidth = 16
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  launch,
    input  logic [sampleBitwidth-1:0]             num_samples,
    input  logic [inputBitwidth-1:0]              s_data,
    input  logic                                  s_valid,
    output logic                                  s_ready,
    input  logic                                  w_ce,
    input  logic                                  x_ce,
    output logic [inputBitwidth*size*numUnit-1:0] data_in,
    output logic                                  start,
    output logic                                  done,
    output logic                                  busy,
    output logic                                  underrun
);
    localparam int ELEMS = size * numUnit;
    localparam int EW    = (ELEMS > 1) ? $clog2(ELEMS) : 1;
    localparam int CW    = sampleBitwidth + logNumCycle + 1;
    localparam logic [EW-1:0] LAST_ELEM   = EW'(ELEMS - 1);
    localparam logic [CW-1:0] NUM_CYCLE_C = CW'(numCycle);

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

    state_t        state_reg, state_next;
    logic [1:0]    valid_reg;
    logic          fill_ptr_reg;
    logic          head_ptr_reg;
    logic [EW-1:0] elem_reg;
    logic [CW-1:0] rows_in_reg;
    logic [CW-1:0] rows_out_reg;
    logic [CW-1:0] rows_out_next;
    logic [CW-1:0] total_rows_reg;
    logic          underrun_reg;

    logic active;
    logic head_valid;
    logic ce;
    logic accept;
    logic row_last;
    logic consume;
    logic take_launch;

    assign active        = (state_reg == LOAD) || (state_reg == RUN);
    assign head_valid    = valid_reg[head_ptr_reg];
    assign ce            = w_ce | x_ce;
    assign s_ready       = active && !valid_reg[fill_ptr_reg] && (rows_in_reg < total_rows_reg);
    assign accept        = s_valid & s_ready;
    assign row_last      = accept && (elem_reg == LAST_ELEM);
    assign consume       = ce & head_valid;
    assign rows_out_next = rows_out_reg + CW'(consume);
    assign take_launch   = (state_reg == IDLE) && launch;

    assign start    = (state_reg == LOAD) && head_valid;
    assign done     = (state_reg == DONE);
    assign busy     = (state_reg != IDLE);
    assign underrun = underrun_reg;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (launch) state_next = LOAD;
            LOAD: if (head_valid) state_next = RUN;
            // >= also catches a block finished by a consume taken while still in LOAD
            RUN:  if (rows_out_next >= total_rows_reg) state_next = DONE;
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg      <= IDLE;
            valid_reg      <= '0;
            fill_ptr_reg   <= 1'b0;
            head_ptr_reg   <= 1'b0;
            elem_reg       <= '0;
            rows_in_reg    <= '0;
            rows_out_reg   <= '0;
            total_rows_reg <= '0;
            underrun_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (take_launch) begin
                total_rows_reg <= NUM_CYCLE_C * (CW'(num_samples) + CW'(1));
                valid_reg      <= '0;
                fill_ptr_reg   <= 1'b0;
                head_ptr_reg   <= 1'b0;
                elem_reg       <= '0;
                rows_in_reg    <= '0;
                rows_out_reg   <= '0;
                underrun_reg   <= 1'b0;
            end else begin
                if (accept) begin
                    elem_reg <= row_last ? '0 : elem_reg + EW'(1);
                end
                // Fill and head never address the same buffer when both fire together.
                if (row_last) begin
                    valid_reg[fill_ptr_reg] <= 1'b1;
                    fill_ptr_reg            <= ~fill_ptr_reg;
                    rows_in_reg             <= rows_in_reg + CW'(1);
                end
                if (consume) begin
                    valid_reg[head_ptr_reg] <= 1'b0;
                    head_ptr_reg            <= ~head_ptr_reg;
                    rows_out_reg            <= rows_out_next;
                end else if (ce) begin
                    underrun_reg <= 1'b1;
                end
            end
        end
    end

    // One storage lane per element slot; the payload needs no reset because valid bits gate it.
    for (genvar gi = 0; gi < ELEMS; gi++) begin : g_lane
        logic [inputBitwidth-1:0] lane_reg [2];

        always_ff @(posedge clk) begin
            if (accept && (elem_reg == EW'(gi))) begin
                lane_reg[fill_ptr_reg] <= s_data;
            end
        end

        assign data_in[gi*inputBitwidth +: inputBitwidth] =
            head_valid ? lane_reg[head_ptr_reg] : '0;
    end

endmodule

// File: tb/tb_axiline_input_loader.sv
// Randomized bench for axiline_input_loader. A queue-based row model predicts every
// output on every cycle.
module tb_axiline_input_loader;
    localparam int IW  = 8;
    localparam int SZ  = 4;
    localparam int NU  = 1;
    localparam int LNC = 1;
    localparam int NC  = 2;
    localparam int SBW = 16;
    localparam int EL  = SZ * NU;
    localparam int RW  = IW * EL;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           launch = 1'b0;
    logic [SBW-1:0] num_samples = '0;
    logic [IW-1:0]  s_data = '0;
    logic           s_valid = 1'b0;
    logic           w_ce = 1'b0;
    logic           x_ce = 1'b0;
    logic           s_ready;
    logic [RW-1:0]  data_in;
    logic           start;
    logic           done;
    logic           busy;
    logic           underrun;

    axiline_input_loader #(
        .inputBitwidth (IW),
        .size          (SZ),
        .numUnit       (NU),
        .logNumCycle   (LNC),
        .numCycle      (NC),
        .sampleBitwidth(SBW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .launch     (launch),
        .num_samples(num_samples),
        .s_data     (s_data),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .w_ce       (w_ce),
        .x_ce       (x_ce),
        .data_in    (data_in),
        .start      (start),
        .done       (done),
        .busy       (busy),
        .underrun   (underrun)
    );

    always #5 clk = ~clk;

    typedef enum int {M_IDLE, M_LOAD, M_RUN, M_DONE} mphase_t;

    int            n_cmp = 0;
    int            n_bad = 0;
    int            cyc = 0;
    mphase_t       m_phase;
    logic [RW-1:0] m_q[$];
    logic [RW-1:0] m_part;
    int            m_cnt;
    int            m_rows_in;
    int            m_rows_out;
    int            m_total;
    bit            m_underrun;
    logic [IW-1:0] cur_byte;
    bit            seq_mode;
    int            obs_starts;
    int            obs_dones;
    int            obs_beats;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s cycle=%0d got=%h want=%h", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_phase    = M_IDLE;
        m_q.delete();
        m_part     = '0;
        m_cnt      = 0;
        m_rows_in  = 0;
        m_rows_out = 0;
        m_total    = 0;
        m_underrun = 0;
    endtask

    task automatic next_byte();
        cur_byte = seq_mode ? cur_byte + 8'd1 : 8'($urandom);
    endtask

    // Called just after a rising edge: drive inputs, check at the falling edge, advance the model.
    task automatic cycle(input bit l, input logic [SBW-1:0] ns, input bit v, input bit wc, input bit xc);
        bit            exp_ready;
        bit            acc;
        bit            had_row;
        logic [RW-1:0] exp_data;
        launch      = l;
        num_samples = ns;
        s_valid     = v;
        w_ce        = wc;
        x_ce        = xc;
        s_data      = cur_byte;
        @(negedge clk);
        had_row   = (m_q.size() > 0);
        exp_ready = (m_phase == M_LOAD || m_phase == M_RUN) && (m_q.size() < 2) && (m_rows_in < m_total);
        exp_data  = '0;
        if (had_row) exp_data = m_q[0];
        check_eq("s_ready",  64'(s_ready),  64'(exp_ready));
        check_eq("data_in",  64'(data_in),  64'(exp_data));
        check_eq("start",    64'(start),    64'(m_phase == M_LOAD && had_row));
        check_eq("done",     64'(done),     64'(m_phase == M_DONE));
        check_eq("busy",     64'(busy),     64'(m_phase != M_IDLE));
        check_eq("underrun", 64'(underrun), 64'(m_underrun));
        if (start) obs_starts++;
        if (done) obs_dones++;
        if (s_ready && s_valid) obs_beats++;
        if (m_phase == M_IDLE) begin
            if (l) begin
                model_reset();
                m_total = NC * (1 + int'(ns));
                m_phase = M_LOAD;
            end
        end else begin
            acc = v && exp_ready;
            if ((wc || xc) && had_row) begin
                $display("cycle %0d: consume row %0d of %0d data_in=%h", cyc, m_rows_out, m_total, m_q[0]);
                void'(m_q.pop_front());
                m_rows_out++;
            end else if (wc || xc) begin
                m_underrun = 1;
            end
            if (acc) begin
                m_part |= RW'(cur_byte) << (IW * m_cnt);
                m_cnt++;
                next_byte();
                if (m_cnt == EL) begin
                    m_q.push_back(m_part);
                    m_part = '0;
                    m_cnt  = 0;
                    m_rows_in++;
                end
            end
            case (m_phase)
                M_LOAD: if (had_row) m_phase = M_RUN;
                M_RUN:  if (m_rows_out >= m_total) m_phase = M_DONE;
                M_DONE: m_phase = M_IDLE;
                default: m_phase = M_IDLE;
            endcase
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_epoch(input int ns, input int vprob, input int ceprob,
                             input bit ce_when_present, input bit seq, input bit early_ce);
        int budget;
        bit v;
        bit c;
        bit l;
        bit wsel;
        seq_mode = seq;
        if (seq) cur_byte = 8'd0;
        obs_starts = 0;
        obs_dones  = 0;
        obs_beats  = 0;
        cycle(1'b1, SBW'(ns), 1'b0, 1'b0, 1'b0);
        if (early_ce) begin
            cycle(1'b0, '0, 1'b0, 1'b1, 1'b0);
            check_eq("underrun_set", 64'(underrun), 64'd1);
            check_eq("underrun_no_row", 64'(data_in), 64'd0);
        end
        budget = 0;
        while (budget < 3000 && m_phase != M_IDLE) begin
            v    = int'($urandom_range(99)) < vprob;
            c    = (m_phase == M_LOAD || m_phase == M_RUN) && (int'($urandom_range(99)) < ceprob)
                   && (!ce_when_present || m_q.size() > 0);
            l    = (m_phase == M_DONE) || ($urandom_range(31) == 0);
            wsel = (m_rows_out < NC);
            cycle(l, 16'($urandom), v, c && wsel, c && !wsel);
            budget++;
        end
        check_eq("epoch_timeout", 64'(budget < 3000), 64'd1);
        check_eq("start_count", 64'(obs_starts), 64'd1);
        check_eq("done_count", 64'(obs_dones), 64'd1);
        check_eq("beat_count", 64'(obs_beats), 64'(NC * (1 + ns) * EL));
        check_eq("idle_ready", 64'(s_ready), 64'd0);
        check_eq("idle_busy", 64'(busy), 64'd0);
    endtask

    initial begin
        model_reset();
        seq_mode = 0;
        cur_byte = 8'd0;
        obs_starts = 0;
        obs_dones  = 0;
        obs_beats  = 0;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("rst_s_ready",  64'(s_ready),  64'd0);
        check_eq("rst_data_in",  64'(data_in),  64'd0);
        check_eq("rst_start",    64'(start),    64'd0);
        check_eq("rst_done",     64'(done),     64'd0);
        check_eq("rst_busy",     64'(busy),     64'd0);
        check_eq("rst_underrun", 64'(underrun), 64'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Basic epoch: sequential bytes, no backpressure, consume each row as it appears.
        run_epoch(1, 100, 100, 1'b1, 1'b1, 1'b0);
        // Backpressure: rare consumes so both buffers fill and s_ready drops.
        run_epoch(2, 100, 8, 1'b0, 1'b0, 1'b0);
        // Underrun: consume strobe in LOAD before any beat.
        run_epoch(1, 70, 40, 1'b0, 1'b0, 1'b1);
        // Zero samples: weight block only.
        run_epoch(0, 100, 50, 1'b0, 1'b0, 1'b0);
        // Full-rate fill with immediate consume exercises simultaneous fill and consume.
        run_epoch(3, 100, 100, 1'b1, 1'b0, 1'b0);

        // Asynchronous reset between edges with one row held and a partial row in flight.
        seq_mode = 0;
        cycle(1'b1, 16'd2, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 50 && !(m_rows_in == 1 && m_cnt == 3); i++) begin
            cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
        end
        check_eq("pre_reset_row", 64'(data_in != '0 || m_q.size() == 0), 64'd1);
        #2;
        rst = 1'b0;
        #1;
        check_eq("arst_s_ready",  64'(s_ready),  64'd0);
        check_eq("arst_data_in",  64'(data_in),  64'd0);
        check_eq("arst_start",    64'(start),    64'd0);
        check_eq("arst_done",     64'(done),     64'd0);
        check_eq("arst_busy",     64'(busy),     64'd0);
        check_eq("arst_underrun", 64'(underrun), 64'd0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        run_epoch(1, 80, 60, 1'b0, 1'b0, 1'b0);

        for (int k = 0; k < 12; k++) begin
            run_epoch(int'($urandom_range(4)), int'($urandom_range(100, 30)), int'($urandom_range(100, 15)),
                      1'($urandom_range(1)), 1'b0, 1'($urandom_range(1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
